pipe_rr_arbiter: RTL

//  Shares one downstream pipeline stage between N_REQ upstream requesters using round-robin.
//  - Each requester presents pipeline_data_t with a valid/ready handshake.
//  - A single-entry holding register feeds the stage with the valid/processed protocol.
//  - Sits in front of a one-entry pipeline FIFO stage; the source id travels with the data.

---
 rtl/pipe_rr_arbiter_if.sv | 32 +++
 rtl/pipe_rr_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/pipe_rr_arbiter_if.sv
// Shared data type and requester/stage handshake bundle for pipe_rr_arbiter.
// The arbiter uses the slave modport; the requesters and the downstream stage drive the master side.
package pipe_rr_arbiter_pkg;
  localparam int unsigned DATA_W = 8;
  typedef logic [DATA_W-1:0] pipeline_data_t;
endpackage

interface pipe_rr_arbiter_if
  import pipe_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] valid_i;
  pipeline_data_t   data_i [N_REQ];
  logic [N_REQ-1:0] ready_o;
  logic             valid_o;
  pipeline_data_t   data_o;
  logic [ID_W-1:0]  src_id_o;
  logic             processed;

  modport master (
    output valid_i, data_i, processed,
    input  ready_o, valid_o, data_o, src_id_o
  );

  modport slave (
    input  valid_i, data_i, processed,
    output ready_o, valid_o, data_o, src_id_o
  );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter sharing one holding register among N_REQ requesters.
// Optional per-requester grant counters are built when PIPE_ARB_STATS_EN is defined.
module pipe_rr_arbiter
  import pipe_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
`ifdef PIPE_ARB_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  pipe_rr_arbiter_if.slave   bus
`ifdef PIPE_ARB_STATS_EN
  , input  logic             cnt_clr_i
  , output logic [CNT_W-1:0] grant_cnt_o [N_REQ]
`endif
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("pipe_rr_arbiter: N_REQ must be within 2..16");
  end

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic            grant_vld;
  logic            accept;
  int unsigned     scan_idx;
  pipeline_data_t  data_q;
  logic [ID_W-1:0] src_q;

  // Scan from rr_ptr upwards with wrap; the first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = 32'(rr_ptr) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!grant_vld && bus.valid_i[ID_W'(scan_idx)]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(scan_idx);
      end
    end
  end

  assign accept = (state == EMPTY) && grant_vld;

  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (grant_vld)     state_nxt = FULL;
      FULL:  if (bus.processed) state_nxt = EMPTY;
    endcase
  end

  // Outputs are forced idle while rst is low so nothing leaks before the first edge.
  always_comb begin
    bus.ready_o  = '0;
    bus.valid_o  = 1'b0;
    bus.data_o   = '0;
    bus.src_id_o = '0;
    if (rst) begin
      bus.valid_o  = (state == FULL);
      bus.data_o   = data_q;
      bus.src_id_o = src_q;
      if (accept) bus.ready_o[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
      data_q <= '0;
      src_q  <= '0;
    end else if (accept) begin
      data_q <= bus.data_i[grant_id];
      src_q  <= grant_id;
      rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

`ifdef PIPE_ARB_STATS_EN
  // Saturating counters; clear has priority over a same-cycle grant.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!rst || cnt_clr_i) begin
        grant_cnt_o[i] <= '0;
      end else if (accept && grant_id == ID_W'(i) && grant_cnt_o[i] != '1) begin
        grant_cnt_o[i] <= grant_cnt_o[i] + 1'b1;
      end
    end
  end
`endif

endmodule
